shifter_and_rotator: RTL and testbench

Single-position 8-bit (parameterisable) shifter/rotator with a registered output. It performs a logical shift left, a fill-one shift right, a rotate left or a rotate right on a data word, selected per cycle by a 2-bit mode code. It sits in the datapath as a one-cycle pipelined utility stage feeding ALU-style result muxing.

---
 rtl/shifter_and_rotator.sv | 67 ++++++
 tb/tb_shifter_and_rotator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/shifter_and_rotator.sv
// Single-position shifter/rotator with a registered result.
// select[0] picks direction (0 = left, 1 = right), select[1] picks kind (0 = shift, 1 = rotate).
// Shifts insert FILL_LEFT at the LSB (left) or FILL_RIGHT at the MSB (right).
// Optional feature macro: SAR_ZERO_FLAG_EN adds a registered result-is-zero flag on port zero.
`timescale 1ns / 1ps

module shifter_and_rotator #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        FILL_LEFT  = 1'b0,
  parameter logic        FILL_RIGHT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       select,
`ifdef SAR_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] y
);

  localparam logic [1:0] SelShl = 2'b00;
  localparam logic [1:0] SelShr = 2'b01;
  localparam logic [1:0] SelRol = 2'b10;
  localparam logic [1:0] SelRor = 2'b11;

  logic [WIDTH-1:0] y_d, y_q;

  // Next result: one-position permutation of x chosen by select.
  always_comb begin
    y_d = '0;
    unique case (select)
      SelShl:  y_d = {x[WIDTH-2:0], FILL_LEFT};
      SelShr:  y_d = {FILL_RIGHT, x[WIDTH-1:1]};
      SelRol:  y_d = {x[WIDTH-2:0], x[WIDTH-1]};
      SelRor:  y_d = {x[0], x[WIDTH-1:1]};
      default: y_d = '0;
    endcase
  end

  // Result register; reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

`ifdef SAR_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag tracks the value being loaded into y_q, so it stays aligned with y.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= (y_d == '0);
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_shifter_and_rotator.sv
// Scoreboard bench for shifter_and_rotator: stimulus pushes expected results,
// a monitor pops and compares one result per clock after each rising edge.
`timescale 1ns / 1ps

module tb_shifter_and_rotator;

  logic       clk;
  logic       rst;
  logic [7:0] x;
  logic [1:0] select;
  logic [7:0] y;
`ifdef SAR_ZERO_FLAG_EN
  logic       zero;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic [7:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  shifter_and_rotator #(
    .WIDTH     (8),
    .FILL_LEFT (1'b0),
    .FILL_RIGHT(1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .select(select),
`ifdef SAR_ZERO_FLAG_EN
    .zero  (zero),
`endif
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input set on the falling edge and record its expected result.
  task automatic apply(input logic r, input logic [7:0] xv, input logic [1:0] sv,
                       input logic [7:0] ey, input logic ez, input logic [7:0] tag);
    exp_t e;
    @(negedge clk);
    rst    = r;
    x      = xv;
    select = sv;
    e.y    = ey;
    e.z    = ez;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new result every cycle, shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (y !== e.y) begin
        errors++;
        $display("FAIL y vec%0d: got %h expected %h", e.tag, y, e.y);
      end
`ifdef SAR_ZERO_FLAG_EN
      checks++;
      if (zero !== e.z) begin
        errors++;
        $display("FAIL zero vec%0d: got %b expected %b", e.tag, zero, e.z);
      end
`endif
    end
  end

  initial begin
    int budget;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    x      = 8'hFF;
    select = 2'b00;

    // Reset held two cycles with nonzero operand
    apply(1'b1, 8'hFF, 2'b00, 8'h00, 1'b1, 8'd0);
    apply(1'b1, 8'hFF, 2'b00, 8'h00, 1'b1, 8'd1);
    // Shift left
    apply(1'b0, 8'hFF, 2'b00, 8'hFE, 1'b0, 8'd2);
    apply(1'b0, 8'h80, 2'b00, 8'h00, 1'b1, 8'd3);
    // Shift right, fill one
    apply(1'b0, 8'hFF, 2'b01, 8'hFF, 1'b0, 8'd4);
    apply(1'b0, 8'h01, 2'b01, 8'h80, 1'b0, 8'd5);
    // Rotate left
    apply(1'b0, 8'hF0, 2'b10, 8'hE1, 1'b0, 8'd6);
    apply(1'b0, 8'h80, 2'b10, 8'h01, 1'b0, 8'd7);
    // Rotate right
    apply(1'b0, 8'h0F, 2'b11, 8'h87, 1'b0, 8'd8);
    apply(1'b0, 8'h01, 2'b11, 8'h80, 1'b0, 8'd9);
    // Back-to-back mode changes on A5
    apply(1'b0, 8'hA5, 2'b00, 8'h4A, 1'b0, 8'd10);
    apply(1'b0, 8'hA5, 2'b01, 8'hD2, 1'b0, 8'd11);
    apply(1'b0, 8'hA5, 2'b10, 8'h4B, 1'b0, 8'd12);
    apply(1'b0, 8'hA5, 2'b11, 8'hD2, 1'b0, 8'd13);
    apply(1'b0, 8'hA5, 2'b00, 8'h4A, 1'b0, 8'd14);
    // Reset mid-stream dominates a changing operand, then results resume
    apply(1'b0, 8'hA5, 2'b01, 8'hD2, 1'b0, 8'd15);
    apply(1'b1, 8'h3C, 2'b10, 8'h00, 1'b1, 8'd16);
    apply(1'b0, 8'hA5, 2'b10, 8'h4B, 1'b0, 8'd17);
    apply(1'b0, 8'h00, 2'b11, 8'h00, 1'b1, 8'd18);
    apply(1'b0, 8'h00, 2'b01, 8'h80, 1'b0, 8'd19);

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
